alu_mc: RTL
===========

# alu_mc

Multicycle, parametrised ALU for the datapath execute stage. It supersedes the purely combinational ALU with a start/done handshake, operand latching, iterative shift-add multiply and restoring divide, bitwise logic ops and a divide-by-zero flag. Single-cycle ops complete one clock after start. MULT/DIV occupy the unit for WIDTH cycles while the control unit stalls on `busy`.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4, power of two)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted on a rising edge when `busy`=0
- Op1  in  WIDTH  operand A, latched on accept
- Op2  in  WIDTH  operand B, latched on accept
- S_Op  in  3  operation select, latched on accept
- busy  out  1  high while MULT/DIV iterating
- done  out  1  one-cycle pulse: R_Op/ZF/DZ updated this cycle
- R_Op  out  WIDTH  registered result, held until next completion
- ZF  out  1  1 iff R_Op == 0; registered with R_Op
- DZ  out  1  1 iff last completed op was DIV with Op2 == 0

## Operation
- Encoding of S_Op: 000 ADD, 001 SUB, 010 MULT, 011 DIV, 100 OR, 101 AND, 110 SLT, 111 SLL.
- All arithmetic is unsigned modulo 2^WIDTH.
- ADD/SUB wrap. MULT returns the low WIDTH bits of the product. DIV returns the unsigned quotient.
- OR/AND are bitwise, not logical.
- SLT yields 1 if Op1 < Op2 (unsigned), else 0.
- SLL shifts Op1 left by Op2. If Op2 ≥ WIDTH, the result is 0.
- DIV with Op2 == 0 is treated as a single-cycle op: R_Op = all ones, DZ = 1. Every other completion clears DZ.
- FSM has three states: IDLE, MUL, DIV.
  - IDLE + start + single-cycle op (including DIV by zero): register the result, pulse `done`, remain in IDLE.
  - IDLE + start + MULT: load the multiplicand, multiplier and accumulator, set the iteration counter to WIDTH-1, go to MUL.
  - IDLE + start + DIV (Op2 ≠ 0): load the dividend, divisor and zero remainder, set the counter to WIDTH-1, go to DIV.
  - MUL/DIV: one iteration per cycle. When counter == 0, register the result, pulse `done`, return to IDLE. Otherwise decrement.
- `start` while `busy`=1 is ignored. The request is not queued.
- Op1/Op2/S_Op changes after accept have no effect on the running op.
- `rst` at any time, including mid-MUL/DIV: abort the op, go to IDLE, no `done` pulse.
- Reset values: busy 0, done 0, R_Op 0, ZF 1, DZ 0.

## Timing
- Cycle 0 is the rising edge where `start` is accepted.
- Single-cycle ops: `done`=1 and results valid in cycle 1. `busy` stays 0.
- MULT/DIV: `busy`=1 in cycles 1..WIDTH. `done`=1 and results valid in cycle WIDTH+1, with `busy`=0 in that same cycle.
  - Latency is WIDTH+1 cycles; for WIDTH=32 that is 33.
- Back-to-back: a start asserted in the `done` cycle is accepted, because `busy` is already 0.
  - Throughput: 1 op/cycle for single-cycle ops; WIDTH+1 cycles per MULT/DIV.
- `done` is never high in two consecutive cycles from a single accept.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Package `alu_pkg` holds:
  - the S_Op encoding constants (OP_ADD … OP_SLL)
  - the FSM state type (ST_IDLE, ST_MUL, ST_DIV)
  - the counter width function clog2(WIDTH)
- Sub-module `alu_muldiv_iter` (parameter WIDTH):
  - shared shift register, accumulator/remainder, subtractor and counter
  - interface: load/mode/step in; result and last out
- The top-level `alu_mc` contains:
  - the single-cycle combinational result mux
  - the FSM
  - the output registers (R_Op, ZF, DZ, done)

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 -> R_Op 0x00000000, ZF 1, done in cycle 1, busy never 1. Then SUB 0 − 1 -> 0xFFFFFFFF, ZF 0.
- MULT 12345 × 6789 -> R_Op 83810205, busy cycles 1..32, done in cycle 33. MULT 0x10000 × 0x10000 -> R_Op 0, ZF 1.
- DIV 100 / 7 -> R_Op 14, DZ 0, done in cycle 33. DIV 5 / 0 -> R_Op 0xFFFFFFFF, DZ 1, done in cycle 1. A following ADD 1+1 clears DZ.
- Start MULT 3 × 4, then drive start with ADD and different operands in cycles 2..10 -> the ADD is ignored and R_Op = 12 at cycle 33. A new start in the done cycle is accepted, with its done one cycle later.
- Assert rst in cycle 10 of DIV 1000 / 3 -> no done pulse; R_Op 0, ZF 1, DZ 0, busy 0. The next DIV 9 / 3 returns 3.
- Logic/shift/compare:
  - AND 0xF0 & 0x3C -> 0x30
  - OR 0xF0 | 0x0F -> 0xFF
  - SLL 1 << 31 -> 0x80000000
  - SLL 1 << 32 -> 0, ZF 1
  - SLT 3 < 2 -> 0
  - SLT 0x00000001 < 0xFFFFFFFF -> 1

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, FSM state type and helpers for the multicycle ALU
// Purpose: S_Op operation encodings, FSM state enum, counter-width function.
// Ports: none (package).
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared iterative shift-add multiplier / restoring divider
// Purpose: one MULT or DIV iteration per step; WIDTH steps per operation.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            latch op_a/op_b/mode, clear accumulator, counter = WIDTH-1
//   mode            0 = multiply, 1 = divide (sampled on load)
//   step            perform one iteration
//   op_a, op_b      multiplicand/dividend, multiplier/divisor
//   result          value the current step produces (product low bits or quotient)
//   last            counter is 0: the current step is the final one
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int CW = clog2(WIDTH);

  // sh: multiplicand (shifts left) / dividend shifting out, quotient shifting in
  // opb: multiplier (shifts right) / divisor (constant)
  // acc: product accumulator / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    sh_d   = sh_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    // Restoring divide: shift next dividend bit into the remainder and try
    // subtracting the divisor; the extra top bit is the borrow.
    trial  = {acc_q, sh_q[WIDTH-1]} - {1'b0, opb_q};
    if (load) begin
      sh_d   = op_a;
      opb_d  = op_b;
      acc_d  = '0;
      cnt_d  = CW'(WIDTH - 1);
      mode_d = mode;
    end else if (step) begin
      if (!mode_q) begin
        if (opb_q[0]) begin
          acc_d = acc_q + sh_q;
        end
        sh_d  = sh_q << 1;
        opb_d = opb_q >> 1;
      end else begin
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    result = mode_q ? sh_d : acc_d;
    last   = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      opb_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      opb_q  <= opb_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multicycle ALU with start/done handshake
// Purpose: single-cycle ADD/SUB/OR/AND/SLT/SLL and DIV-by-zero; WIDTH-cycle MULT/DIV.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request, accepted when busy = 0
//   Op1, Op2, S_Op       operands and operation select, latched on accept
//   busy                 MULT/DIV iterating
//   done                 one-cycle pulse when R_Op/ZF/DZ update
//   R_Op, ZF, DZ         registered result, zero flag, divide-by-zero flag
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic [2:0]       S_Op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R_Op,
  output logic             ZF,
  output logic             DZ
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_op_q, r_op_d;
  logic             zf_q, zf_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sc_res;
  logic             it_load, it_mode, it_step, it_last;
  logic [WIDTH-1:0] it_result;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (it_load),
    .mode   (it_mode),
    .step   (it_step),
    .op_a   (Op1),
    .op_b   (Op2),
    .result (it_result),
    .last   (it_last)
  );

  always_comb begin
    sc_res = '0;
    case (S_Op)
      OP_ADD: sc_res = Op1 + Op2;
      OP_SUB: sc_res = Op1 - Op2;
      OP_OR:  sc_res = Op1 | Op2;
      OP_AND: sc_res = Op1 & Op2;
      OP_SLT: sc_res = WIDTH'(Op1 < Op2);
      // Full-width compare so shift amounts >= WIDTH give 0 instead of wrapping.
      OP_SLL: sc_res = (Op2 >= WIDTH'(WIDTH)) ? '0 : (Op1 << Op2[CW-1:0]);
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_op_d  = r_op_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    it_load = 1'b0;
    it_mode = 1'b0;
    it_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (S_Op == OP_MULT) begin
            it_load = 1'b1;
            state_d = ST_MUL;
          end else if (S_Op == OP_DIV && Op2 != '0) begin
            it_load = 1'b1;
            it_mode = 1'b1;
            state_d = ST_DIV;
          end else if (S_Op == OP_DIV) begin
            r_op_d = '1;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            r_op_d = sc_res;
            dz_d   = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        it_step = 1'b1;
        if (it_last) begin
          r_op_d  = it_result;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // r_op_d equals r_op_q except on completion, so ZF tracks R_Op exactly.
    zf_d = (r_op_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_op_q  <= '0;
      zf_q    <= 1'b1;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_op_q  <= r_op_d;
      zf_q    <= zf_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign R_Op = r_op_q;
  assign ZF   = zf_q;
  assign DZ   = dz_q;

endmodule
